// File: rtl/piece_fall_ctrl.sv
// piece_fall_ctrl: falling-piece stage of the 8x4 block game.
// Takes a spawned board from clear_redraw. It keeps the falling piece apart
// from the settled stack and applies gravity and left/right shifts. On landing
// it merges the piece into the stack, reports LOCK for one cycle and returns
// to GEN.
//
// Board word: row r at bits [4r+3:4r], row 0 is the top, column c is bit 4r+c.
//
// Ports:
//   clka        clock, posedge
//   restart_n   async active-low reset
//   start       spawn-valid pulse (honoured in GEN only)
//   board_in    stack plus newly spawned piece
//   curr_piece  shape code of the spawned piece
//   error_in    spawn-overlap error, sends the game to OVER
//   move_left   shift request, sampled each FALL cycle
//   move_right  shift request, sampled each FALL cycle
//   soft_drop   forces a gravity step this cycle
//   board_out   registered stack | piece
//   state       0 GEN, 1 FALL, 2 LOCK, 3 OVER
//   landed      one-cycle pulse, high together with state=LOCK
//   game_over   high while in OVER
//
// state | meaning
// GEN   | waiting for a spawn from clear_redraw
// FALL  | piece falling, gravity timer running, moves accepted
// LOCK  | piece merged into stack, clear_redraw clears full lines
// OVER  | spawn collided, frozen until reset
module piece_fall_ctrl #(
  parameter int unsigned DROP_TICKS = 4
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  input  logic [31:0] board_in,
  input  logic [1:0]  curr_piece,
  input  logic        error_in,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        soft_drop,
  output logic [31:0] board_out,
  output logic [2:0]  state,
  output logic        landed,
  output logic        game_over
);

  typedef enum logic [2:0] {
    GEN  = 3'd0,
    FALL = 3'd1,
    LOCK = 3'd2,
    OVER = 3'd3
  } phase_t;

  localparam logic [7:0]  TICK_LAST = 8'(DROP_TICKS - 1);
  localparam logic [31:0] LEFT_COL  = 32'h1111_1111;
  localparam logic [31:0] RIGHT_COL = 32'h8888_8888;

  phase_t      phase_q, phase_d;
  logic [31:0] stack_q, stack_d;
  logic [31:0] piece_q, piece_d;
  logic [7:0]  tick_q, tick_d;
  logic        landed_d;
  logic [31:0] spawn_mask;
  logic [31:0] fall_cand, left_cand, right_cand;
  logic        grav_step, fall_blocked, left_ok, right_ok;

  always_comb begin
    spawn_mask = 32'h0000_0002;
    case (curr_piece)
      2'b00: spawn_mask = 32'h0000_0002;
      2'b01: spawn_mask = 32'h0000_0006;
      2'b10: spawn_mask = 32'h0000_0066;
      2'b11: spawn_mask = 32'h0000_0062;
      default: spawn_mask = 32'h0000_0002;
    endcase
  end

  assign fall_cand  = piece_q << 4;
  assign left_cand  = piece_q >> 1;
  assign right_cand = piece_q << 1;

  assign grav_step    = (tick_q == TICK_LAST) || soft_drop;
  // Any piece bit in row 7 would shift out of the word, so it counts as blocked.
  assign fall_blocked = (|piece_q[31:28]) || (|(fall_cand & stack_q));
  assign left_ok      = ~(|(piece_q & LEFT_COL))  && ~(|(left_cand & stack_q));
  assign right_ok     = ~(|(piece_q & RIGHT_COL)) && ~(|(right_cand & stack_q));

  always_comb begin
    phase_d  = phase_q;
    stack_d  = stack_q;
    piece_d  = piece_q;
    tick_d   = tick_q;
    landed_d = 1'b0;
    unique case (phase_q)
      GEN: begin
        if (start) begin
          if (error_in) begin
            phase_d = OVER;
          end else begin
            piece_d = spawn_mask;
            stack_d = board_in & ~spawn_mask;
            tick_d  = '0;
            phase_d = FALL;
          end
        end
      end
      FALL: begin
        if (grav_step) begin
          tick_d = '0;
          if (fall_blocked) begin
            stack_d  = stack_q | piece_q;
            piece_d  = '0;
            phase_d  = LOCK;
            landed_d = 1'b1;
          end else begin
            piece_d = fall_cand;
          end
        end else begin
          // Cannot wrap: a counter at TICK_LAST always takes the gravity branch.
          tick_d = tick_q + 8'd1;
          if (move_left && !move_right && left_ok) begin
            piece_d = left_cand;
          end else if (move_right && !move_left && right_ok) begin
            piece_d = right_cand;
          end
        end
      end
      LOCK: phase_d = GEN;
      OVER: phase_d = OVER;
      default: phase_d = GEN;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      phase_q   <= GEN;
      stack_q   <= '0;
      piece_q   <= '0;
      tick_q    <= '0;
      landed    <= 1'b0;
      board_out <= '0;
    end else begin
      phase_q   <= phase_d;
      stack_q   <= stack_d;
      piece_q   <= piece_d;
      tick_q    <= tick_d;
      landed    <= landed_d;
      board_out <= stack_d | piece_d;
    end
  end

  assign state     = phase_q;
  assign game_over = (phase_q == OVER);

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Testbench for piece_fall_ctrl. The reference model keeps the board as an
// 8x4 grid of stack cells and piece cells. Each driven cycle pushes the
// expected outputs onto a scoreboard queue. A monitor pops and compares them
// one step after the clock edge.
module tb_piece_fall_ctrl;
  localparam int DT = 4;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] board_in = '0;
  logic [1:0]  curr_piece = '0;
  logic        error_in = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        soft_drop = 1'b0;
  logic [31:0] board_out;
  logic [2:0]  state;
  logic        landed;
  logic        game_over;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] board;
    logic [2:0]  st;
    logic        ld;
    logic        go;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: grid cells, phase code, cycles since last gravity step.
  bit stk[8][4];
  bit pg[8][4];
  int m_phase = 0;
  int m_ticks = 0;
  bit m_landed = 1'b0;

  piece_fall_ctrl #(.DROP_TICKS(DT)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .board_in(board_in),
    .curr_piece(curr_piece), .error_in(error_in), .move_left(move_left),
    .move_right(move_right), .soft_drop(soft_drop), .board_out(board_out),
    .state(state), .landed(landed), .game_over(game_over)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (stk[r, c]) stk[r][c] = 1'b0;
    foreach (pg[r, c]) pg[r][c] = 1'b0;
    m_phase = 0;
    m_ticks = 0;
    m_landed = 1'b0;
  endtask

  function automatic bit can_shift(input int dr, input int dc);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (pg[r][c]) begin
          if (r + dr > 7 || c + dc < 0 || c + dc > 3) return 1'b0;
          if (stk[r + dr][c + dc]) return 1'b0;
        end
    return 1'b1;
  endfunction

  task automatic shift_piece(input int dr, input int dc);
    bit tmp[8][4];
    foreach (tmp[r, c]) tmp[r][c] = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (pg[r][c]) tmp[r + dr][c + dc] = 1'b1;
    pg = tmp;
  endtask

  function automatic logic [31:0] model_board();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        b[4*r + c] = stk[r][c] | pg[r][c];
    return b;
  endfunction

  task automatic model_step(input bit st, input logic [1:0] cp, input logic [31:0] bi,
                            input bit er, input bit ml, input bit mr, input bit sd);
    m_landed = 1'b0;
    case (m_phase)
      0: if (st) begin
        if (er) m_phase = 3;
        else begin
          foreach (pg[r, c]) pg[r][c] = 1'b0;
          case (cp)
            2'd0: pg[0][1] = 1'b1;
            2'd1: begin pg[0][1] = 1'b1; pg[0][2] = 1'b1; end
            2'd2: begin pg[0][1] = 1'b1; pg[0][2] = 1'b1; pg[1][1] = 1'b1; pg[1][2] = 1'b1; end
            default: begin pg[0][1] = 1'b1; pg[1][1] = 1'b1; pg[1][2] = 1'b1; end
          endcase
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
              stk[r][c] = bi[4*r + c] && !pg[r][c];
          m_ticks = 0;
          m_phase = 1;
        end
      end
      1: begin
        if (m_ticks == DT - 1 || sd) begin
          m_ticks = 0;
          if (can_shift(1, 0)) shift_piece(1, 0);
          else begin
            foreach (pg[r, c]) begin
              if (pg[r][c]) stk[r][c] = 1'b1;
              pg[r][c] = 1'b0;
            end
            m_phase = 2;
            m_landed = 1'b1;
          end
        end else begin
          m_ticks++;
          if (ml && !mr && can_shift(0, -1)) shift_piece(0, -1);
          else if (mr && !ml && can_shift(0, 1)) shift_piece(0, 1);
        end
      end
      2: m_phase = 0;
      default: ;
    endcase
  endtask

  // Drive one clock cycle of inputs, record the expected result, return #1 after the edge.
  task automatic step(input bit st, input logic [1:0] cp, input logic [31:0] bi,
                      input bit er, input bit ml, input bit mr, input bit sd);
    exp_t e;
    @(negedge clka);
    start = st; curr_piece = cp; board_in = bi; error_in = er;
    move_left = ml; move_right = mr; soft_drop = sd;
    model_step(st, cp, bi, er, ml, mr, sd);
    e.board = model_board();
    e.st = 3'(m_phase);
    e.ld = m_landed;
    e.go = (m_phase == 3);
    sb_q.push_back(e);
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 32'h0, 0, 0, 0, 0);
  endtask

  // Reset is asserted mid-cycle, so any change seen here comes from the async path.
  task automatic do_reset();
    @(negedge clka);
    #2;
    start = 0; error_in = 0; move_left = 0; move_right = 0; soft_drop = 0;
    board_in = '0; curr_piece = '0;
    restart_n = 1'b0;
    #1;
    chk("rst_board", board_out, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_landed", 32'(landed), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    model_reset();
    @(negedge clka);
    #2;
    restart_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clka);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_board", board_out, e.board);
        chk("sb_state", 32'(state), 32'(e.st));
        chk("sb_landed", 32'(landed), 32'(e.ld));
        chk("sb_game_over", 32'(game_over), 32'(e.go));
      end
    end
  end

  initial begin : stim
    model_reset();
    #7;
    chk("por_board", board_out, 32'h0);
    chk("por_state", 32'(state), 32'd0);
    chk("por_landed", 32'(landed), 32'd0);
    chk("por_game_over", 32'(game_over), 32'd0);
    @(negedge clka);
    #2;
    restart_n = 1'b1;

    // Single cell falls to the bottom, then the blocked step locks it.
    step(1, 2'd0, 32'h2, 0, 0, 0, 0);
    chk("a_spawn", board_out, 32'h2);
    idle(31);
    chk("a_bottom", board_out, 32'h2000_0000);
    chk("a_bottom_state", 32'(state), 32'd1);
    idle(1);
    chk("a_lock_state", 32'(state), 32'd2);
    chk("a_lock_landed", 32'(landed), 32'd1);
    chk("a_lock_board", board_out, 32'h2000_0000);
    idle(1);
    chk("a_gen_state", 32'(state), 32'd0);
    chk("a_gen_landed", 32'(landed), 32'd0);

    // Left wall stops the piece.
    do_reset();
    step(1, 2'd1, 32'h6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 32'h0, 0, 1, 0, 0);
      chk("b_left", board_out, 32'h3);
    end
    // Right wall stops the piece.
    do_reset();
    step(1, 2'd1, 32'h6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 32'h0, 0, 0, 1, 0);
      chk("b_right", board_out, 32'hC);
    end
    // Both requests together cancel.
    do_reset();
    step(1, 2'd1, 32'h6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 32'h0, 0, 1, 1, 0);
      chk("b_both", board_out, 32'h6);
    end

    // Soft drop onto a filled row, then the spawn error freezes the game.
    do_reset();
    step(1, 2'd1, 32'h0000_0F06, 0, 0, 0, 0);
    chk("d_spawn", board_out, 32'h0000_0F06);
    step(0, 2'd0, 32'h0, 0, 0, 0, 1);
    chk("d_drop", board_out, 32'h0000_0F60);
    step(0, 2'd0, 32'h0, 0, 0, 0, 1);
    chk("d_lock_board", board_out, 32'h0000_0F60);
    chk("d_lock_landed", 32'(landed), 32'd1);
    chk("d_lock_state", 32'(state), 32'd2);
    idle(1);
    step(1, 2'd2, 32'h0000_0F66, 1, 0, 0, 0);
    chk("e_over_state", 32'(state), 32'd3);
    chk("e_over_flag", 32'(game_over), 32'd1);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("e_hold_board", board_out, 32'h0000_0F60);
    chk("e_hold_state", 32'(state), 32'd3);

    // Asynchronous reset while the piece sits at 0x600.
    do_reset();
    step(1, 2'd1, 32'h6, 0, 0, 0, 0);
    idle(8);
    chk("f_before_reset", board_out, 32'h600);
    do_reset();

    // A move in the gravity cycle is dropped; one in the next cycle applies.
    step(1, 2'd0, 32'h2, 0, 0, 0, 0);
    idle(3);
    chk("g_no_step_yet", board_out, 32'h2);
    step(0, 2'd0, 32'h0, 0, 1, 0, 0);
    chk("g_step_move_ignored", board_out, 32'h20);
    step(0, 2'd0, 32'h0, 0, 1, 0, 0);
    chk("g_move_after_step", board_out, 32'h10);

    // Randomized play.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else
        step(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             $urandom & $urandom & $urandom, 1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0));
    end

    @(negedge clka);
    #2;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piece_fall_ctrl.md
Name: piece_fall_ctrl

Overview:
- Gameplay stage paired with clear_redraw on the 8-row x 4-column board.
- Word layout: row r occupies bits [4r+3:4r]; row 0 is the top (spawn) row and row 7 is the bottom. Column c is bit 4r+c; column 0 is the left.
- Accepts the spawned board from clear_redraw, holds the falling piece separately from the settled stack, and applies gravity and left/right moves.
- On landing it drives state to LOCK so clear_redraw clears full lines, then returns to GEN for the next spawn.

Parameters:
- DROP_TICKS, 4, clka cycles between gravity steps in FALL (legal range 2..255).

Ports:
- clka  in  1  system clock; all logic on posedge.
- restart_n  in  1  asynchronous active-low reset.
- start  in  1  spawn-valid pulse: board_in holds the stack plus the newly generated piece.
- board_in  in  32  board from clear_redraw.
- curr_piece  in  2  shape code of the spawned piece (same encoding as clear_redraw).
- error_in  in  1  spawn-overlap error from clear_redraw.
- move_left  in  1  shift request, sampled each cycle in FALL.
- move_right  in  1  shift request, sampled each cycle in FALL.
- soft_drop  in  1  forces a gravity step this cycle.
- board_out  out  32  registered stack | piece.
- state  out  3  phase code: 0 GEN, 1 FALL, 2 LOCK, 3 OVER.
- landed  out  1  one-cycle pulse when a piece locks.
- game_over  out  1  sticky; high while in OVER.

Behaviour:
- Reset (asynchronous, restart_n=0):
  - board_out=0, stack=0, piece=0, state=GEN(0).
  - landed=0, game_over=0, tick counter=0.
  - Reset mid-FALL discards the falling piece.
- Spawn mask from curr_piece:
  - 00 -> 0x00000002
  - 01 -> 0x00000006
  - 10 -> 0x00000066
  - 11 -> 0x00000062
- GEN: wait for start.
  - start=1 and error_in=1 -> OVER next cycle.
  - start=1 and error_in=0 -> next cycle: piece=mask, stack=board_in & ~mask, counter=0, state=FALL.
- FALL, once per cycle:
  - Gravity step when counter==DROP_TICKS-1 or soft_drop=1.
    - Blocked if piece has any bit in row 7 (piece[31:28]!=0) or ((piece<<4) & stack)!=0.
    - Not blocked: piece <= piece<<4; counter <= 0.
    - Blocked: go to LOCK, stack <= stack|piece, piece <= 0, landed=1 for exactly that cycle.
    - Move requests in a gravity-step cycle are ignored.
  - Otherwise, counter increments and moves are evaluated:
    - Exactly one of move_left/move_right is high:
      - Left candidate = piece>>1; blocked if piece & 0x11111111.
      - Right candidate = piece<<1; blocked if piece & 0x88888888.
      - Also blocked if candidate & stack != 0.
      - Blocked -> piece unchanged.
    - Both high, or neither -> no move.
- LOCK: lasts exactly one cycle with state=2, so clear_redraw runs its clear branch. Then GEN.
- OVER: state=3, game_over=1; board_out holds its last value. Exit only via reset. All inputs are ignored.
- board_out <= stack | piece, registered every cycle; it reflects the update one cycle after the causing event.
- The counter is 8 bits and never exceeds DROP_TICKS-1; it is cleared on every gravity step and on spawn.
- start outside GEN is ignored.

Test Plan:
- Empty board, curr_piece=00, board_in=0x2, start, DROP_TICKS=4:
  - Piece reaches 0x20000000 after 7 gravity steps.
  - The 8th step is blocked: landed pulses, state=2 for one cycle then 0, board_out=0x20000000.
- curr_piece=01, board_in=0x6, move_left held 3 cycles (no gravity step):
  - board_out 0x6 -> 0x3, then stays 0x3.
  - Separately, move_right: 0x6 -> 0xC, then stays 0xC.
  - Both requests high together -> board_out stays 0x6.
- board_in=0x00000F06, curr_piece=01, soft_drop=1:
  - Piece moves to 0x60 (board_out=0x00000F60).
  - Next step is blocked: lock with board_out=0x00000F60, landed=1.
- start with error_in=1:
  - Next cycle state=3 and game_over=1.
  - Later start, move and soft_drop pulses change nothing until restart_n=0.
- Reset mid-FALL: restart_n low asynchronously while piece at 0x600 -> board_out=0, state=0 immediately, without waiting for a clock edge.
- DROP_TICKS=4 with no inputs:
  - Gravity steps occur exactly every 4 cycles.
  - A move_left in the step cycle is ignored; one in the following cycle takes effect.
